// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Shared constants and entry type for the IF/ID decoupling queue.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

    // Datapath width and the canonical RISC-V NOP (addi x0, x0, 0)
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // One queue slot: PC in the upper half, instruction in the lower half
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

endpackage : if_id_queue_pkg
`default_nettype wire

// File: rtl/if_id_queue_storage.sv
`default_nettype none
// ============================================================================
// Module      : ifq_storage
// Description : DEPTH x 64-bit register array, one write port and one
//               combinational read port. The data array has no reset; the
//               controller guarantees empty slots never reach the output.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ifq_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output ifq_entry_t       rdata
);

    ifq_entry_t r_mem [DEPTH];

    // Write the addressed slot only when the controller accepts a word
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : ifq_storage
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Show-ahead FIFO between fetch and decode. Fetch is throttled
//               through PC_write, a taken branch (PCSrc) drains the queue, and
//               decode sees a NOP whenever no valid entry is present.
//               Optional feature macro IF_ID_QUEUE_STATS_EN adds saturating
//               stall_cnt / flush_cnt outputs; the datapath is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] PC_IF,
    input  logic [XLEN-1:0] INSTRUCTION_IF,
    output logic            PC_write,
    input  logic            PCSrc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] PC_ID,
`ifdef IF_ID_QUEUE_STATS_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic [XLEN-1:0] INSTRUCTION_ID
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_depth_cnt = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_one_cnt   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_one_ptr   = PTR_W'(1);

    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic             w_enq;
    logic             w_deq;
    logic             w_we;
    ifq_entry_t       w_wdata;
    ifq_entry_t       w_head;

    // Handshakes derive from registered occupancy only, so PC_write never
    // depends on id_ready and a full queue cannot accept on its draining cycle
    assign PC_write = (r_count != c_depth_cnt);
    assign id_valid = (r_count != '0);
    assign w_enq    = if_valid & PC_write;
    assign w_deq    = id_valid & id_ready;

    // A flush-cycle word is wrong-path, so it is never written
    assign w_we          = w_enq & ~PCSrc & ~reset;
    assign w_wdata.pc    = PC_IF;
    assign w_wdata.instr = INSTRUCTION_IF;

    ifq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // Pointer and occupancy control: reset, then flush, then enq/deq
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (PCSrc) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_one_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_one_ptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_one_cnt;
                2'b01:   r_count <= r_count - c_one_cnt;
                default: r_count <= r_count;
            endcase
        end
    end

    // Mask the head so stale slot contents never leak to decode
    assign PC_ID          = id_valid ? w_head.pc    : '0;
    assign INSTRUCTION_ID = id_valid ? w_head.instr : NOP_INSTR;

`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters for decode stalls and branch flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (id_valid && !id_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (PCSrc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule : if_id_queue
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Scoreboard bench for if_id_queue. The stimulus side keeps an
//               ordered list of accepted {PC, instruction} words; a monitor
//               compares the DUT head, valid and back-pressure against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic        PC_write;
    logic        PCSrc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] PC_ID;
    logic [31:0] INSTRUCTION_ID;
`ifdef IF_ID_QUEUE_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   acc;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF),
        .PC_write       (PC_write),
        .PCSrc          (PCSrc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .PC_ID          (PC_ID),
`ifdef IF_ID_QUEUE_STATS_EN
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .INSTRUCTION_ID (INSTRUCTION_ID)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus; the queue model is updated at the edge it models
    task automatic cyc(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, output bit accepted);
        int occ;
        reset = rst; PCSrc = fl; if_valid = iv;
        PC_IF = pc; INSTRUCTION_IF = ins; id_ready = rdy;
        occ = exp_q.size();
        accepted = !rst && !fl && iv && (occ < DEPTH);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (occ > 0 && !rdy) m_stall++;
            if (fl) begin
                exp_q.delete();
                m_flush++;
            end else if (accepted) begin
                exp_q.push_back('{pc, ins});
            end
        end
        #1;
    endtask

    function automatic logic [31:0] mk_ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Monitor: compares the presented head and pops it when decode takes it
    initial begin
        forever begin
            @(negedge clk);
            check("id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
            check("PC_write", {31'b0, PC_write}, {31'b0, exp_q.size() != DEPTH});
            if (exp_q.size() != 0) begin
                check("PC_ID", PC_ID, exp_q[0].pc);
                check("INSTRUCTION_ID", INSTRUCTION_ID, exp_q[0].ins);
                if (id_ready && !reset && !PCSrc) void'(exp_q.pop_front());
            end else begin
                check("PC_ID_idle", PC_ID, 32'h0);
                check("INSTRUCTION_ID_nop", INSTRUCTION_ID, NOP);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        reset = 1'b1; PCSrc = 1'b0; if_valid = 1'b0;
        PC_IF = '0; INSTRUCTION_IF = '0; id_ready = 1'b0;

        // Reset then idle
        cyc(1, 0, 0, 0, 0, 0, acc);
        cyc(1, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);

        // Streaming 0,4,8 with decode always ready
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'(4*i), mk_ins(32'(4*i)), 1, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);

        // Stall fill: two words fill, the third is held off until space frees
        cyc(0, 0, 1, 32'h10, mk_ins(32'h10), 0, acc);
        cyc(0, 0, 1, 32'h14, mk_ins(32'h14), 0, acc);
        cyc(0, 0, 1, 32'h18, mk_ins(32'h18), 0, acc);
        check("held_off", {31'b0, acc}, 32'h0);
        for (int i = 0; i < 4 && !acc; i++) cyc(0, 0, 1, 32'h18, mk_ins(32'h18), 1, acc);
        check("third_accepted", {31'b0, acc}, 32'h1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, acc);

        // Flush while full: the flush-cycle word 0x28 must never reach decode
        cyc(0, 0, 1, 32'h20, mk_ins(32'h20), 0, acc);
        cyc(0, 0, 1, 32'h24, mk_ins(32'h24), 0, acc);
        cyc(0, 1, 1, 32'h28, mk_ins(32'h28), 0, acc);
        cyc(0, 0, 1, 32'h100, mk_ins(32'h100), 0, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);

        // Wrap: six enq/deq pairs around the two-entry ring
        cyc(0, 0, 1, 32'h200, mk_ins(32'h200), 1, acc);
        for (int i = 1; i < 6; i++) cyc(0, 0, 1, 32'h200 + 32'(4*i), mk_ins(32'h200 + 32'(4*i)), 1, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);

        // Stats: three stall cycles and one flush since the last reset
        cyc(1, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 1, 32'h300, mk_ins(32'h300), 0, acc);
        cyc(0, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, acc);
        cyc(0, 1, 0, 0, 0, 0, acc);
`ifdef IF_ID_QUEUE_STATS_EN
        cyc(0, 0, 0, 0, 0, 1, acc);
        check("stall_cnt_3", stall_cnt, 32'd3);
        check("flush_cnt_1", flush_cnt, 32'd1);
`endif

        // Reset mid-stall with a full queue
        cyc(0, 0, 1, 32'h400, mk_ins(32'h400), 0, acc);
        cyc(0, 0, 1, 32'h404, mk_ins(32'h404), 0, acc);
        cyc(1, 0, 1, 32'h408, mk_ins(32'h408), 0, acc);
        cyc(0, 0, 0, 0, 0, 0, acc);

        // Randomized traffic with occasional flushes and resets
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            logic r, f, v, rd;
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            cyc(r, f, v, pc, $urandom, rd, acc);
            if (acc) pc = pc + 32'd4;
        end
        cyc(0, 0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 0, 1, acc);
`ifdef IF_ID_QUEUE_STATS_EN
        check("stall_cnt_rand", stall_cnt, 32'(m_stall));
        check("flush_cnt_rand", flush_cnt, 32'(m_flush));
`endif
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_id_queue
`default_nettype wire
